reset_sequencer: RTL

Parametrised reset sequencer that generates staged active-low resets for several design domains on the system clock. It merges hard reset, watchdog timeout, software reset request and an external reset pin. It holds all domains in reset for a stretch period, then releases them one by one in a fixed order. It records which source caused the last reset in a sticky cause register that firmware can read and clear.

---
 rtl/reset_sequencer_if.sv | 34 +++
 rtl/reset_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - trigger, cause and staged reset signals of the reset sequencer
interface reset_sequencer_if #(
  parameter int NUM_OUTPUTS = 3
);
  logic                   watchdog_timeout;
  logic                   sw_reset_req;
  logic                   ext_reset_n;
  logic                   cause_clear;
  logic [NUM_OUTPUTS-1:0] rst_n_out;
  logic [2:0]             cause;
  logic                   busy;

  // Trigger sources and firmware side drive the sequencer.
  modport master (
    output watchdog_timeout,
    output sw_reset_req,
    output ext_reset_n,
    output cause_clear,
    input  rst_n_out,
    input  cause,
    input  busy
  );

  // The sequencer itself.
  modport slave (
    input  watchdog_timeout,
    input  sw_reset_req,
    input  ext_reset_n,
    input  cause_clear,
    output rst_n_out,
    output cause,
    output busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release with sticky reset cause
module reset_sequencer #(
  parameter int NUM_OUTPUTS = 3,
  parameter int HOLD_CYCLES = 200,
  parameter int STAGE_DELAY = 16,
  parameter int CTR_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam logic [CTR_WIDTH-1:0]   HOLD_LAST  = CTR_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CTR_WIDTH-1:0]   STAGE_LAST = CTR_WIDTH'(STAGE_DELAY - 1);
  localparam logic [3:0]             LAST_STAGE = 4'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ONE_BIT    = NUM_OUTPUTS'(1);

  state_t                 state;
  logic [CTR_WIDTH-1:0]   ctr;
  logic [2:0]             stage;
  logic [NUM_OUTPUTS-1:0] rst_n_out_r;
  logic                   busy_r;
  logic [2:0]             cause_r;
  logic                   ext_sync1;
  logic                   ext_sync2;

  logic                   ext_trig;
  logic                   trig;
  logic [3:0]             next_stage;

  // The synchronised pin idles high, so a low level is a reset request.
  assign ext_trig   = ~ext_sync2;
  assign trig       = bus.watchdog_timeout | bus.sw_reset_req | ext_trig;
  assign next_stage = {1'b0, stage} + 4'd1;

  // Two-flop synchroniser for the asynchronous external reset pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync1 <= 1'b1;
      ext_sync2 <= 1'b1;
    end else begin
      ext_sync1 <= bus.ext_reset_n;
      ext_sync2 <= ext_sync1;
    end
  end

  // Sequencer: any trigger restarts the hold stretch, then domains release in index order.
  always_ff @(posedge clk) begin
    if (rst || trig) begin
      state       <= S_HOLD;
      ctr         <= '0;
      stage       <= '0;
      rst_n_out_r <= '0;
      busy_r      <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          if (ctr == HOLD_LAST) begin
            rst_n_out_r <= ONE_BIT;
            ctr         <= '0;
            stage       <= '0;
            if (NUM_OUTPUTS == 1) begin
              state  <= S_RUN;
              busy_r <= 1'b0;
            end else begin
              state  <= S_RELEASE;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        S_RELEASE: begin
          if (ctr == STAGE_LAST) begin
            rst_n_out_r <= rst_n_out_r | (ONE_BIT << next_stage);
            stage       <= next_stage[2:0];
            ctr         <= '0;
            if (next_stage == LAST_STAGE) begin
              state  <= S_RUN;
              busy_r <= 1'b0;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        S_RUN: begin
          rst_n_out_r <= '1;
          busy_r      <= 1'b0;
        end
        default: begin
          state       <= S_HOLD;
          ctr         <= '0;
          stage       <= '0;
          rst_n_out_r <= '0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  // Sticky cause: active sources set their bit, and beat a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_r <= 3'b000;
    end else begin
      cause_r <= (bus.cause_clear ? 3'b000 : cause_r)
               | {ext_trig, bus.sw_reset_req, bus.watchdog_timeout};
    end
  end

  assign bus.rst_n_out = rst_n_out_r;
  assign bus.busy      = busy_r;
  assign bus.cause     = cause_r;

endmodule
